armleocpu_alu_mdu: RTL and testbench

Parametrised, XLEN-wide execute unit merging the base integer ALU with an iterative RV-M multiply/divide engine behind a valid/ready request/response handshake. Single-cycle ALU ops return on the next cycle. MUL/DIV/REM families run in a bit-serial engine over XLEN cycles. Sits in the execute stage and stalls the pipeline through `req_ready`/`rsp_valid`. A `kill` input lets a pipeline flush abort an in-flight operation.

---
 rtl/armleocpu_alu_mdu_pkg.sv | 55 +++++
 rtl/armleocpu_muldiv_iter.sv | 77 +++++++
 rtl/armleocpu_alu_mdu.sv | 183 ++++++++++++++++++
 tb/tb_armleocpu_alu_mdu.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_alu_mdu_pkg.sv
// Shared op codes, FSM state encodings and op-class helpers for the ALU/MDU execute unit.
package armleocpu_alu_mdu_pkg;

  localparam int unsigned OP_W = 5;

  // Bit 4 marks an M-extension op; bit 2 of an M op selects the divide family.
  typedef enum logic [OP_W-1:0] {
    ARMLEOCPU_MDU_OP_ADD    = 5'd0,
    ARMLEOCPU_MDU_OP_SUB    = 5'd1,
    ARMLEOCPU_MDU_OP_SLT    = 5'd2,
    ARMLEOCPU_MDU_OP_SLTU   = 5'd3,
    ARMLEOCPU_MDU_OP_SLL    = 5'd4,
    ARMLEOCPU_MDU_OP_SRL    = 5'd5,
    ARMLEOCPU_MDU_OP_SRA    = 5'd6,
    ARMLEOCPU_MDU_OP_XOR    = 5'd7,
    ARMLEOCPU_MDU_OP_OR     = 5'd8,
    ARMLEOCPU_MDU_OP_AND    = 5'd9,
    ARMLEOCPU_MDU_OP_MUL    = 5'd16,
    ARMLEOCPU_MDU_OP_MULH   = 5'd17,
    ARMLEOCPU_MDU_OP_MULHSU = 5'd18,
    ARMLEOCPU_MDU_OP_MULHU  = 5'd19,
    ARMLEOCPU_MDU_OP_DIV    = 5'd20,
    ARMLEOCPU_MDU_OP_DIVU   = 5'd21,
    ARMLEOCPU_MDU_OP_REM    = 5'd22,
    ARMLEOCPU_MDU_OP_REMU   = 5'd23
  } mdu_op_e;

  typedef enum logic [1:0] {
    ARMLEOCPU_MDU_STATE_IDLE = 2'd0,
    ARMLEOCPU_MDU_STATE_CALC = 2'd1,
    ARMLEOCPU_MDU_STATE_FIX  = 2'd2,
    ARMLEOCPU_MDU_STATE_DONE = 2'd3
  } mdu_state_e;

  // Codes 24..31 are not M ops; they fall through to ADD like any unknown code.
  function automatic logic is_m_op(input logic [OP_W-1:0] op);
    return op[4] && !op[3];
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return is_m_op(op) && op[2];
  endfunction

  function automatic logic op1_signed(input logic [OP_W-1:0] op);
    return (op == ARMLEOCPU_MDU_OP_MUL) || (op == ARMLEOCPU_MDU_OP_MULH) ||
           (op == ARMLEOCPU_MDU_OP_MULHSU) || (op == ARMLEOCPU_MDU_OP_DIV) ||
           (op == ARMLEOCPU_MDU_OP_REM);
  endfunction

  function automatic logic op2_signed(input logic [OP_W-1:0] op);
    return (op == ARMLEOCPU_MDU_OP_MUL) || (op == ARMLEOCPU_MDU_OP_MULH) ||
           (op == ARMLEOCPU_MDU_OP_DIV) || (op == ARMLEOCPU_MDU_OP_REM);
  endfunction

endpackage

// File: rtl/armleocpu_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) / restoring divide engine, one bit per cycle.
module armleocpu_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done_c,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic              busy_q;
  logic              div_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q;

  logic [XLEN:0]     mul_sum_c;
  logic [XLEN:0]     div_shift_c;
  logic [XLEN:0]     div_diff_c;
  logic              div_ge_c;
  logic [2*XLEN-1:0] acc_step_c;

  // Multiply: acc = {partial hi, multiplier-aligned lo}, shifted right each step.
  // Divide: acc = {remainder, dividend->quotient}, shifted left each step.
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_shift_c = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_c  = div_shift_c - {1'b0, b_q};
    div_ge_c    = !div_diff_c[XLEN];
    acc_step_c  = {mul_sum_c, acc_q[XLEN-1:1]};
    if (div_q) begin
      acc_step_c = {(div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0]),
                    acc_q[XLEN-2:0], div_ge_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (kill) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= CW'(XLEN - 1);
      a_q    <= a;
      b_q    <= b;
      acc_q  <= is_div ? {{XLEN{1'b0}}, a} : '0;
    end else if (busy_q) begin
      acc_q <= acc_step_c;
      cnt_q <= cnt_q - CW'(1);
      if (!div_q) begin
        b_q <= b_q >> 1;
      end
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_c = busy_q && (cnt_q == '0);
  assign acc_o  = acc_q;

endmodule

// File: rtl/armleocpu_alu_mdu.sv
// Execute unit: single-cycle ALU plus iterative RV-M multiply/divide behind valid/ready handshakes.
module armleocpu_alu_mdu
  import armleocpu_alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            req_shamt_sel,
  input  logic [SHW-1:0]  req_shamt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, op_d, req_op_e;
  logic       neg_q, neg_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [SHW-1:0]  shamt_c;
  logic signed [XLEN-1:0] sra_c;
  logic [XLEN-1:0] alu_res_c;
  logic            m_c, div_c, rem_c, div0_c, ovf_c, fast_c, slow_c;
  logic            neg1_c, neg2_c, res_neg_c;
  logic [XLEN-1:0] mag1_c, mag2_c, fast_res_c;
  logic            accept_c, start_c;
  logic            iter_done_c;
  logic [2*XLEN-1:0] iter_acc;
  logic [2*XLEN-1:0] prod_fix_c;
  logic [XLEN-1:0] quot_fix_c, rem_fix_c, fix_res_c;

  assign req_op_e = mdu_op_e'(req_op);

  // Single-cycle ALU; unknown codes behave as ADD.
  always_comb begin
    shamt_c   = req_shamt_sel ? req_op2[SHW-1:0] : req_shamt;
    sra_c     = $signed(req_op1) >>> shamt_c;
    alu_res_c = req_op1 + req_op2;
    case (req_op_e)
      ARMLEOCPU_MDU_OP_SUB:  alu_res_c = req_op1 - req_op2;
      ARMLEOCPU_MDU_OP_SLT:  alu_res_c = XLEN'($signed(req_op1) < $signed(req_op2));
      ARMLEOCPU_MDU_OP_SLTU: alu_res_c = XLEN'(req_op1 < req_op2);
      ARMLEOCPU_MDU_OP_SLL:  alu_res_c = req_op1 << shamt_c;
      ARMLEOCPU_MDU_OP_SRL:  alu_res_c = req_op1 >> shamt_c;
      ARMLEOCPU_MDU_OP_SRA:  alu_res_c = sra_c;
      ARMLEOCPU_MDU_OP_XOR:  alu_res_c = req_op1 ^ req_op2;
      ARMLEOCPU_MDU_OP_OR:   alu_res_c = req_op1 | req_op2;
      ARMLEOCPU_MDU_OP_AND:  alu_res_c = req_op1 & req_op2;
      default:               alu_res_c = req_op1 + req_op2;
    endcase
  end

  // M-op classification, divide fast paths and operand magnitudes.
  always_comb begin
    m_c    = is_m_op(req_op);
    div_c  = is_div_op(req_op);
    rem_c  = req_op[1];
    div0_c = (req_op2 == '0);
    ovf_c  = !req_op[0] && (req_op1 == MIN_VAL) && (req_op2 == '1);
    fast_c = div_c && (div0_c || ovf_c);
    slow_c = m_c && !fast_c;
    if (div0_c) begin
      fast_res_c = rem_c ? req_op1 : '1;
    end else begin
      fast_res_c = rem_c ? '0 : MIN_VAL;
    end
    neg1_c    = op1_signed(req_op) && req_op1[XLEN-1];
    neg2_c    = op2_signed(req_op) && req_op2[XLEN-1];
    mag1_c    = neg1_c ? -req_op1 : req_op1;
    mag2_c    = neg2_c ? -req_op2 : req_op2;
    res_neg_c = (div_c && rem_c) ? neg1_c : (neg1_c ^ neg2_c);
  end

  assign req_ready = !kill && ((state_q == ARMLEOCPU_MDU_STATE_IDLE) ||
                               ((state_q == ARMLEOCPU_MDU_STATE_DONE) && rsp_ready));
  assign accept_c  = req_valid && req_ready;

  armleocpu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .start  (start_c),
    .is_div (div_c),
    .a      (mag1_c),
    .b      (mag2_c),
    .done_c (iter_done_c),
    .acc_o  (iter_acc)
  );

  // Sign fixup and high/low or quotient/remainder selection in FIX.
  always_comb begin
    prod_fix_c = neg_q ? -iter_acc : iter_acc;
    quot_fix_c = neg_q ? -iter_acc[XLEN-1:0] : iter_acc[XLEN-1:0];
    rem_fix_c  = neg_q ? -iter_acc[2*XLEN-1:XLEN] : iter_acc[2*XLEN-1:XLEN];
    case (op_q)
      ARMLEOCPU_MDU_OP_MUL:    fix_res_c = prod_fix_c[XLEN-1:0];
      ARMLEOCPU_MDU_OP_MULH,
      ARMLEOCPU_MDU_OP_MULHSU,
      ARMLEOCPU_MDU_OP_MULHU:  fix_res_c = prod_fix_c[2*XLEN-1:XLEN];
      ARMLEOCPU_MDU_OP_DIV,
      ARMLEOCPU_MDU_OP_DIVU:   fix_res_c = quot_fix_c;
      ARMLEOCPU_MDU_OP_REM,
      ARMLEOCPU_MDU_OP_REMU:   fix_res_c = rem_fix_c;
      default:                 fix_res_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    start_c  = 1'b0;
    if (kill) begin
      state_d = ARMLEOCPU_MDU_STATE_IDLE;
    end else begin
      case (state_q)
        ARMLEOCPU_MDU_STATE_IDLE,
        ARMLEOCPU_MDU_STATE_DONE: begin
          if ((state_q == ARMLEOCPU_MDU_STATE_DONE) && rsp_ready) begin
            state_d = ARMLEOCPU_MDU_STATE_IDLE;
          end
          if (accept_c) begin
            if (slow_c) begin
              state_d = ARMLEOCPU_MDU_STATE_CALC;
              start_c = 1'b1;
              op_d    = req_op_e;
              neg_d   = res_neg_c;
            end else begin
              state_d  = ARMLEOCPU_MDU_STATE_DONE;
              result_d = fast_c ? fast_res_c : alu_res_c;
            end
          end
        end
        ARMLEOCPU_MDU_STATE_CALC: begin
          if (iter_done_c) begin
            state_d = ARMLEOCPU_MDU_STATE_FIX;
          end
        end
        ARMLEOCPU_MDU_STATE_FIX: begin
          result_d = fix_res_c;
          state_d  = ARMLEOCPU_MDU_STATE_DONE;
        end
        default: state_d = ARMLEOCPU_MDU_STATE_IDLE;
      endcase
    end
    rsp_valid_d = (state_d == ARMLEOCPU_MDU_STATE_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARMLEOCPU_MDU_STATE_IDLE;
      op_q        <= ARMLEOCPU_MDU_OP_ADD;
      neg_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_armleocpu_alu_mdu.sv
// Bench for armleocpu_alu_mdu: vector table, random ops vs arithmetic model, handshake/kill/reset corners.
module tb_armleocpu_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kill;
  logic        req_valid, req_ready, req_shamt_sel;
  logic [4:0]  req_op, req_shamt;
  logic [31:0] req_op1, req_op2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;

  logic        kill8, req_valid8, req_ready8, req_shamt_sel8, rsp_valid8, rsp_ready8;
  logic [4:0]  req_op8;
  logic [2:0]  req_shamt8;
  logic [7:0]  req_op1_8, req_op2_8, rsp_result8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  armleocpu_alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_shamt_sel(req_shamt_sel), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result)
  );

  armleocpu_alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .kill(kill8),
    .req_valid(req_valid8), .req_ready(req_ready8), .req_op(req_op8),
    .req_op1(req_op1_8), .req_op2(req_op2_8),
    .req_shamt_sel(req_shamt_sel8), .req_shamt(req_shamt8),
    .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready8), .rsp_result(rsp_result8)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ssel;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [4:0] op_list[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RV32 reference: plain signed/unsigned arithmetic on wide integers.
  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic ssel,
                                         input logic [4:0] sh);
    logic [4:0]         s;
    logic signed [31:0] sa, sb;
    logic signed [63:0] wa, wb, wbu, pss, psu;
    logic [63:0]        puu;
    s   = ssel ? b[4:0] : sh;
    sa  = a;
    sb  = b;
    wa  = sa;
    wb  = sb;
    wbu = {32'h0, b};
    pss = wa * wb;
    psu = wa * wbu;
    puu = {32'h0, a} * {32'h0, b};
    case (op)
      5'd1:  return a - b;
      5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  return (a < b) ? 32'd1 : 32'd0;
      5'd4:  return a << s;
      5'd5:  return a >> s;
      5'd6:  return sa >>> s;
      5'd7:  return a ^ b;
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd16: return pss[31:0];
      5'd17: return pss[63:32];
      5'd18: return psu[63:32];
      5'd19: return puu[63:32];
      5'd20: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      5'd21: return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  // Responses arrive on the next cycle except non-trivial MUL/DIV (XLEN CALC cycles + FIX + 1).
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic m, fast;
    m    = op[4] && !op[3];
    fast = m && op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return (m && !fast) ? 34 : 1;
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ssel, input logic [4:0] sh,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    req_op = op; req_op1 = a; req_op2 = b; req_shamt_sel = ssel; req_shamt = sh;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op1 = $urandom; req_op2 = $urandom; req_op = 5'($urandom);
    lat = 0;
    res = 32'hDEADBEEF;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        res = rsp_result;
        break;
      end
    end
  endtask

  task automatic run_op8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output int lat);
    @(negedge clk);
    req_op8 = op; req_op1_8 = a; req_op2_8 = b; req_shamt_sel8 = 1'b0; req_shamt8 = 3'd0;
    req_valid8 = 1'b1; rsp_ready8 = 1'b1;
    @(posedge clk);
    #1;
    req_valid8 = 1'b0; req_op1_8 = 8'($urandom); req_op2_8 = 8'($urandom);
    lat = 0;
    res = 8'hAA;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid8) begin
        lat = i;
        res = rsp_result8;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [7:0]  res8;
    int          lat;
    logic        seen;
    logic [31:0] held;

    op_list = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd12,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

    tbl.push_back('{5'd6,  32'h80000000, 32'h0,        1'b0, 5'd4,  32'hF8000000});
    tbl.push_back('{5'd0,  32'd1,        32'd2,        1'b0, 5'd0,  32'd3});
    tbl.push_back('{5'd1,  32'd3,        32'd5,        1'b0, 5'd0,  32'hFFFFFFFE});
    tbl.push_back('{5'd2,  32'hFFFFFFFF, 32'd1,        1'b0, 5'd0,  32'd1});
    tbl.push_back('{5'd3,  32'hFFFFFFFF, 32'd1,        1'b0, 5'd0,  32'd0});
    tbl.push_back('{5'd4,  32'd1,        32'h23,       1'b1, 5'd9,  32'd8});
    tbl.push_back('{5'd5,  32'h80000000, 32'h0,        1'b0, 5'd31, 32'd1});
    tbl.push_back('{5'd7,  32'hF0F0,     32'hFF00,     1'b0, 5'd0,  32'h0FF0});
    tbl.push_back('{5'd8,  32'hF0F0,     32'hFF00,     1'b0, 5'd0,  32'hFFF0});
    tbl.push_back('{5'd9,  32'hF0F0,     32'hFF00,     1'b0, 5'd0,  32'hF000});
    tbl.push_back('{5'd12, 32'd5,        32'd6,        1'b0, 5'd0,  32'd11});
    tbl.push_back('{5'd17, 32'h80000000, 32'h80000000, 1'b0, 5'd0,  32'h40000000});
    tbl.push_back('{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'hFFFFFFFE});
    tbl.push_back('{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h00000001});
    tbl.push_back('{5'd18, 32'hFFFFFFFF, 32'd2,        1'b0, 5'd0,  32'hFFFFFFFF});
    tbl.push_back('{5'd20, 32'hFFFFFFF9, 32'd2,        1'b0, 5'd0,  32'hFFFFFFFD});
    tbl.push_back('{5'd22, 32'hFFFFFFF9, 32'd2,        1'b0, 5'd0,  32'hFFFFFFFF});
    tbl.push_back('{5'd21, 32'd7,        32'd2,        1'b0, 5'd0,  32'd3});
    tbl.push_back('{5'd23, 32'd7,        32'd2,        1'b0, 5'd0,  32'd1});
    tbl.push_back('{5'd21, 32'd5,        32'd0,        1'b0, 5'd0,  32'hFFFFFFFF});
    tbl.push_back('{5'd23, 32'd5,        32'd0,        1'b0, 5'd0,  32'd5});
    tbl.push_back('{5'd20, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h80000000});
    tbl.push_back('{5'd22, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0});
    tbl.push_back('{5'd20, 32'd5,        32'd0,        1'b0, 5'd0,  32'hFFFFFFFF});
    tbl.push_back('{5'd22, 32'hFFFFFFFB, 32'd0,        1'b0, 5'd0,  32'hFFFFFFFB});

    rst_n = 1'b0; kill = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 5'd0; req_op1 = '0; req_op2 = '0; req_shamt_sel = 1'b0; req_shamt = '0;
    kill8 = 1'b0; req_valid8 = 1'b0; rsp_ready8 = 1'b1; req_op8 = 5'd0;
    req_op1_8 = '0; req_op2_8 = '0; req_shamt_sel8 = 1'b0; req_shamt8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset8_req_ready", req_ready8, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ssel, tbl[i].sh, res, lat);
      chk($sformatf("tbl%0d_op%0d_result", i, tbl[i].op), res, tbl[i].exp);
      chk($sformatf("tbl%0d_op%0d_latency", i, tbl[i].op), lat, exp_lat(tbl[i].op, tbl[i].a, tbl[i].b));
    end

    // SRA then ADD issued back to back while the consumer stalls for 3 cycles.
    @(negedge clk);
    req_op = 5'd6; req_op1 = 32'h80000000; req_op2 = 32'h0; req_shamt_sel = 1'b0; req_shamt = 5'd4;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_op = 5'd0; req_op1 = 32'd1; req_op2 = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_valid", i), rsp_valid, 1);
      chk($sformatf("bp_stall%0d_result", i), rsp_result, 32'hF8000000);
      chk($sformatf("bp_stall%0d_req_ready", i), req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_result", rsp_result, 32'h3);

    // Kill during a slow divide: its result must never appear.
    @(negedge clk);
    req_op = 5'd20; req_op1 = 32'hFFFFFF9C; req_op2 = 32'd7; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      if (i == 10) begin
        kill = 1'b1;
        #1;
        chk("kill_req_ready_low", req_ready, 0);
      end
      if (i == 11) kill = 1'b0;
      if (i == 12) chk("kill_req_ready_n12", req_ready, 1);
    end
    chk("kill_no_response", seen, 0);
    run_op(5'd0, 32'h12345678, 32'd1, 1'b0, 5'd0, res, lat);
    chk("kill_next_add_result", res, 32'h12345679);
    chk("kill_next_add_latency", lat, 1);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    req_op = 5'd16; req_op1 = 32'd3; req_op2 = 32'd5; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_calc_valid", rsp_valid, 0);
    chk("rst_mid_calc_result", rsp_result, 0);
    chk("rst_mid_calc_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_partial_response", seen, 0);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      logic        ssel;
      logic [4:0]  sh;
      int          pick;
      op   = op_list[$urandom_range(0, 18)];
      a    = $urandom;
      b    = $urandom;
      ssel = 1'($urandom);
      sh   = 5'($urandom);
      pick = $urandom_range(0, 7);
      if (pick == 0) b = 32'h0;
      if (pick == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (pick == 2) begin a = a & 32'hFF; b = b & 32'hF; end
      if (pick == 3) b = b | 32'h80000000;
      run_op(op, a, b, ssel, sh, res, lat);
      chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, op, a, b), res, ref_op(op, a, b, ssel, sh));
      chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, exp_lat(op, a, b));
    end

    // Held result must survive an idle gap.
    held = res;
    repeat (3) @(negedge clk);
    chk("idle_result_held", rsp_result, held);

    // Narrow datapath corners.
    run_op8(5'd20, 8'h80, 8'hFF, res8, lat);
    chk("x8_div_ovf_result", res8, 8'h80);
    chk("x8_div_ovf_latency", lat, 1);
    run_op8(5'd19, 8'hFF, 8'hFF, res8, lat);
    chk("x8_mulhu_result", res8, 8'hFE);
    chk("x8_mulhu_latency", lat, 10);
    run_op8(5'd21, 8'hF0, 8'd7, res8, lat);
    chk("x8_divu_result", res8, 8'h22);
    run_op8(5'd23, 8'hF0, 8'd7, res8, lat);
    chk("x8_remu_result", res8, 8'h02);
    run_op8(5'd6, 8'h90, 8'h03, res8, lat);
    chk("x8_sra_result", res8, 8'h90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
